demorgan_sweep_ctrl: RTL and testbench

- Exhaustive-sweep controller for a pair of two-input De Morgan datapaths.
- Form X is ~(a|b); form Y is (~a)&(~b). Both sit outside this block.
- On start, drives every (a,b) operand combination to both forms, samples their outputs, compares them and counts mismatches.
- Reports done/pass status and the first failing vector. Sits between a test/config master and the two gate instances.

---
 rtl/demorgan_sweep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_demorgan_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweep_ctrl.sv
// demorgan_sweep_ctrl: exhaustive operand sweep for two De Morgan gate forms.
// Form X = ~(a|b) and form Y = (~a)&(~b) live outside this block. Every (a,b)
// pair is driven once, the two results are compared after LAT cycles, and
// mismatches are counted and the first failing vector is remembered.
// Optional build macro DEMORGAN_STOP_ON_FAIL_EN ends the sweep at the first
// mismatch. Vectors already in flight are still compared.
module demorgan_sweep_ctrl #(
  parameter int WIDTH = 1,
  parameter int LAT   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic [WIDTH-1:0] res_x,
  input  logic [WIDTH-1:0] res_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             vld_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;

  // Tag leaving the sampling pipeline this cycle, and whether any
  // younger tag is still travelling behind it.
  logic             chk_vld;
  logic [WIDTH-1:0] chk_a;
  logic [WIDTH-1:0] chk_b;
  logic             pending;

  logic             mism;
  logic             stop_req;
  logic [CNT_W-1:0] err_cnt_d;
  logic [WIDTH-1:0] fail_a_d;
  logic [WIDTH-1:0] fail_b_d;

  // The operands are the sweep counter itself: a in the low half, b in the high half.
  assign op_a     = cnt_q[WIDTH-1:0];
  assign op_b     = cnt_q[CW-1:WIDTH];
  assign op_valid = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_a   = fail_a_q;
  assign fail_b   = fail_b_q;

  generate
    if (LAT == 0) begin : g_comb
      // Combinational gates: compare in the same cycle as the drive.
      assign chk_vld = vld_q;
      assign chk_a   = op_a;
      assign chk_b   = op_b;
      assign pending = 1'b0;
    end else begin : g_pipe
      // Stage i holds the vector that was driven i+1 cycles ago.
      localparam logic [LAT-1:0] PEND_MASK = {LAT{1'b1}} >> 1;
      logic [LAT-1:0]            tag_vld_q;
      logic [LAT-1:0][WIDTH-1:0] tag_a_q;
      logic [LAT-1:0][WIDTH-1:0] tag_b_q;

      // Shift {valid, a, b} tags alongside the external gate latency.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tag_vld_q <= '0;
          tag_a_q   <= '0;
          tag_b_q   <= '0;
        end else begin
          tag_vld_q[0] <= vld_q;
          tag_a_q[0]   <= op_a;
          tag_b_q[0]   <= op_b;
          for (int i = 1; i < LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_a_q[i]   <= tag_a_q[i-1];
            tag_b_q[i]   <= tag_b_q[i-1];
          end
        end
      end

      assign chk_vld = tag_vld_q[LAT-1];
      assign chk_a   = tag_a_q[LAT-1];
      assign chk_b   = tag_b_q[LAT-1];
      assign pending = |(tag_vld_q & PEND_MASK);
    end
  endgenerate

  // Compare the exiting tag and work out the next error bookkeeping.
  always_comb begin
    mism      = chk_vld && (res_x != res_y);
    err_cnt_d = err_cnt_q;
    fail_a_d  = fail_a_q;
    fail_b_d  = fail_b_q;
    if (mism) begin
      // The counter saturates and never wraps, so zero means no mismatch yet.
      if (err_cnt_q == '0) begin
        fail_a_d = chk_a;
        fail_b_d = chk_b;
      end
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef DEMORGAN_STOP_ON_FAIL_EN
  assign stop_req = mism;
`else
  assign stop_req = 1'b0;
`endif

  // Sweep FSM: IDLE/DONE accept start, RUN drives vectors, DRAIN empties the tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            vld_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
          end
        end
        S_RUN: begin
          err_cnt_q <= err_cnt_d;
          fail_a_q  <= fail_a_d;
          fail_b_q  <= fail_b_d;
          if (stop_req || (cnt_q == '1)) begin
            // Operands hold their last value while the tags drain.
            vld_q <= 1'b0;
            if (LAT == 0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          err_cnt_q <= err_cnt_d;
          fail_a_q  <= fail_a_d;
          fail_b_q  <= fail_b_d;
          // The tag compared this cycle is the last one still in flight.
          if (!pending) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl. Three instances cover the WIDTH/LAT/CNT_W
// corners; the gate forms around them are modelled here with optional faults.
module tb_demorgan_sweep_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v;
  int          sel;
  int          fmode;   // 0: correct gates, 1: invert Y on fmask vectors, 2: Y stuck at 0
  logic [15:0] fmask;
  int          checks = 0;
  int          errors = 0;

  // Gate models: X is NOR; Y is AND of inverses, optionally faulted per vector index {b,a}.
  function automatic logic [1:0] xfn(input int w, input logic [1:0] a, input logic [1:0] b);
    logic [1:0] m;
    m = (w == 2) ? 2'b11 : 2'b01;
    return ~(a | b) & m;
  endfunction

  function automatic logic [1:0] yfn(input int w, input logic [1:0] a, input logic [1:0] b,
                                     input int mode, input logic [15:0] mask);
    logic [1:0] m;
    logic [1:0] y;
    int v;
    m = (w == 2) ? 2'b11 : 2'b01;
    v = (w == 2) ? int'({b, a}) : int'({b[0], a[0]});
    y = (~a) & (~b) & m;
    if (mode == 1 && mask[v]) y = ~y & m;
    if (mode == 2) y = 2'b00;
    return y;
  endfunction

  // Instance 0: WIDTH=1, LAT=0, CNT_W=8
  logic       op_a0, op_b0, vld0, busy0, done0, pass0, fa0, fb0;
  logic [7:0] err0;
  logic [1:0] rx0, ry0;
  assign rx0 = xfn(1, {1'b0, op_a0}, {1'b0, op_b0});
  assign ry0 = yfn(1, {1'b0, op_a0}, {1'b0, op_b0}, fmode, fmask);

  demorgan_sweep_ctrl #(.WIDTH(1), .LAT(0), .CNT_W(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .op_a(op_a0), .op_b(op_b0), .op_valid(vld0),
    .res_x(rx0[0]), .res_y(ry0[0]),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_a(fa0), .fail_b(fb0));

  // Instance 1: WIDTH=1, LAT=2, CNT_W=8 (gate outputs delayed by two registers)
  logic       op_a1, op_b1, vld1, busy1, done1, pass1, fa1, fb1;
  logic [7:0] err1;
  logic       da1_q0, da1_q1, db1_q0, db1_q1;
  logic [1:0] rx1, ry1;
  always @(posedge clk) begin
    da1_q0 <= op_a1;
    da1_q1 <= da1_q0;
    db1_q0 <= op_b1;
    db1_q1 <= db1_q0;
  end
  assign rx1 = xfn(1, {1'b0, da1_q1}, {1'b0, db1_q1});
  assign ry1 = yfn(1, {1'b0, da1_q1}, {1'b0, db1_q1}, fmode, fmask);

  demorgan_sweep_ctrl #(.WIDTH(1), .LAT(2), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .op_a(op_a1), .op_b(op_b1), .op_valid(vld1),
    .res_x(rx1[0]), .res_y(ry1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_a(fa1), .fail_b(fb1));

  // Instance 2: WIDTH=2, LAT=0, CNT_W=2
  logic [1:0] op_a2, op_b2, fa2, fb2, err2;
  logic       vld2, busy2, done2, pass2;
  logic [1:0] rx2, ry2;
  assign rx2 = xfn(2, op_a2, op_b2);
  assign ry2 = yfn(2, op_a2, op_b2, fmode, fmask);

  demorgan_sweep_ctrl #(.WIDTH(2), .LAT(0), .CNT_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .op_a(op_a2), .op_b(op_b2), .op_valid(vld2),
    .res_x(rx2), .res_y(ry2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_a(fa2), .fail_b(fb2));

  // Observation mux onto the instance selected by sel.
  logic [1:0] m_a, m_b, m_fa, m_fb;
  logic       m_vld, m_busy, m_done, m_pass;
  logic [7:0] m_err;
  always_comb begin
    m_a = '0; m_b = '0; m_fa = '0; m_fb = '0;
    m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_err = '0;
    case (sel)
      0: begin
        m_a = {1'b0, op_a0}; m_b = {1'b0, op_b0}; m_fa = {1'b0, fa0}; m_fb = {1'b0, fb0};
        m_vld = vld0; m_busy = busy0; m_done = done0; m_pass = pass0; m_err = err0;
      end
      1: begin
        m_a = {1'b0, op_a1}; m_b = {1'b0, op_b1}; m_fa = {1'b0, fa1}; m_fb = {1'b0, fb1};
        m_vld = vld1; m_busy = busy1; m_done = done1; m_pass = pass1; m_err = err1;
      end
      default: begin
        m_a = op_a2; m_b = op_b2; m_fa = fa2; m_fb = fb2;
        m_vld = vld2; m_busy = busy2; m_done = done2; m_pass = pass2; m_err = {6'b0, err2};
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sweep on instance s; a start pulse is injected in busy cycle extra_start (0 = none).
  task automatic run_sweep(input int s, input int extra_start, input string tag);
    int w, lat, cw, cap, n, ecnt, eerr, efa, efb, a, b;
    int bcnt, vcnt, seq_bad;
    bit finished;
    case (s)
      0:       begin w = 1; lat = 0; cw = 8; end
      1:       begin w = 1; lat = 2; cw = 8; end
      default: begin w = 2; lat = 0; cw = 2; end
    endcase
    sel = s;
    cap = (1 << cw) - 1;
    n = 1 << (2 * w);
    ecnt = 0; efa = 0; efb = 0;
    for (int v = 0; v < n; v++) begin
      a = v % (1 << w);
      b = v >> w;
      if (xfn(w, a[1:0], b[1:0]) != yfn(w, a[1:0], b[1:0], fmode, fmask)) begin
        if (ecnt == 0) begin efa = a; efb = b; end
        ecnt++;
      end
    end
    eerr = (ecnt > cap) ? cap : ecnt;

    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    bcnt = 0; vcnt = 0; seq_bad = 0; finished = 0;
    for (int i = 0; i < 300 && !finished; i++) begin
      if (m_busy) begin
        if (bcnt == 0)
          chk({tag, "_start_clear"}, {m_err, m_fa, m_fb, m_done}, 0);
        if (m_vld) begin
          if (m_a !== 2'(vcnt % (1 << w)) || m_b !== 2'(vcnt >> w)) seq_bad++;
          vcnt++;
        end
        bcnt++;
        start_v[s] = (bcnt == extra_start);
      end else if (m_done) begin
        finished = 1;
      end
      if (!finished) @(negedge clk);
    end
    start_v[s] = 1'b0;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_busy_cycles"}, bcnt, n + lat);
    chk({tag, "_vectors"}, vcnt, n);
    chk({tag, "_sequence_errs"}, seq_bad, 0);
    chk({tag, "_err_cnt"}, m_err, eerr);
    chk({tag, "_fail_a"}, m_fa, (ecnt > 0) ? efa : 0);
    chk({tag, "_fail_b"}, m_fb, (ecnt > 0) ? efb : 0);
    chk({tag, "_pass"}, m_pass, (ecnt == 0));
    chk({tag, "_vld_low"}, m_vld, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, {m_done, m_busy, m_err, m_fa, m_fb},
        {1'b1, 1'b0, 8'(eerr), 2'((ecnt > 0) ? efa : 0), 2'((ecnt > 0) ? efb : 0)});
  endtask

  // Reset asserted in busy cycle 2 must abort the sweep with no done.
  task automatic run_reset(input int s);
    int  bcnt;
    bit  hit, seen;
    sel = s;
    fmode = 0;
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    bcnt = 0; hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (m_busy) bcnt++;
      if (bcnt == 2) hit = 1;
      else @(negedge clk);
    end
    chk("rst_reach_run2", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {m_a, m_b, m_vld, m_busy, m_done, m_pass, m_err, m_fa, m_fb}, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done || m_busy || m_vld) seen = 1;
    end
    chk("rst_no_done", seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_v = '0; sel = 0; fmode = 0; fmask = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_state", {m_a, m_b, m_vld, m_busy, m_done, m_pass, m_err, m_fa, m_fb}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    fmode = 0;                      run_sweep(0, 0, "w1l0_clean");
    fmode = 1; fmask = 16'h0002;    run_sweep(1, 0, "w1l2_a1b0");
    fmode = 2;                      run_sweep(2, 0, "w2l0_stuck0");
    fmode = 0;                      run_sweep(1, 3, "w1l2_start_ignored");
    run_reset(2);
    fmode = 1; fmask = 16'h0008;    run_sweep(1, 0, "restart_fail");
    fmode = 0;                      run_sweep(1, 0, "restart_clean");

    for (int k = 0; k < 6; k++) begin
      fmode = 1;
      fmask = 16'($urandom);
      run_sweep(int'($urandom_range(0, 2)), 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
